calc2_param: RTL and testbench

Parametrised successor to the four-port calculator.
- N_PORTS request channels, DATA_W-bit operands, two-cycle command/operand protocol per port.
- All ports share one ALU through a round-robin arbiter.
- Optional saturating overflow mode.
- Sits between the requester ports and the result/response bus; each port sees its own response lane.

---
 rtl/calc2_param.sv | 173 +++++++++++++++++
 tb/tb_calc2_param.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc2_param.sv
// Multi-port two-cycle calculator: N_PORTS request channels share one ALU through
// a round-robin arbiter; each port gets a one-cycle response pulse on its own lane.
module calc2_param #(
  parameter int N_PORTS  = 4,
  parameter int DATA_W   = 32,
  parameter int SATURATE = 0
) (
  input  logic                         c_clk,
  input  logic                         reset,
  input  logic [0:N_PORTS*4-1]         req_cmd_in,
  input  logic [0:N_PORTS*DATA_W-1]    req_data_in,
  output logic [0:N_PORTS*2-1]         out_resp,
  output logic [0:N_PORTS*DATA_W-1]    out_data
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int SH_W  = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_PORTS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP2  = 2'd1,
    S_PEND = 2'd2
  } state_e;

  state_e              state_q [N_PORTS];
  state_e              state_d [N_PORTS];
  logic [3:0]          cmd_q   [N_PORTS];
  logic [3:0]          cmd_d   [N_PORTS];
  logic [DATA_W-1:0]   op1_q   [N_PORTS];
  logic [DATA_W-1:0]   op1_d   [N_PORTS];
  logic [DATA_W-1:0]   op2_q   [N_PORTS];
  logic [DATA_W-1:0]   op2_d   [N_PORTS];
  logic [1:0]          resp_q  [N_PORTS];
  logic [1:0]          resp_d  [N_PORTS];
  logic [DATA_W-1:0]   data_q  [N_PORTS];
  logic [DATA_W-1:0]   data_d  [N_PORTS];
  logic [IDX_W-1:0]    last_q;
  logic [IDX_W-1:0]    last_d;
  logic                gnt_vld;
  logic [IDX_W-1:0]    gnt_idx;

  // Returns {resp, data}; out-of-range results either error out or clamp.
  function automatic logic [DATA_W+1:0] alu(input logic [3:0] cmd,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W:0]   sum;
    logic [1:0]        r;
    logic [DATA_W-1:0] d;
    sum = {1'b0, a} + {1'b0, b};
    r   = 2'd2;
    d   = {DATA_W{1'b0}};
    case (cmd)
      4'd1: begin
        if (sum[DATA_W]) begin
          r = (SATURATE != 0) ? 2'd3 : 2'd2;
          d = (SATURATE != 0) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
        end else begin
          r = 2'd1;
          d = sum[DATA_W-1:0];
        end
      end
      4'd2: begin
        if (b > a) begin
          r = (SATURATE != 0) ? 2'd3 : 2'd2;
          d = {DATA_W{1'b0}};
        end else begin
          r = 2'd1;
          d = a - b;
        end
      end
      4'd5: begin
        r = 2'd1;
        d = a << b[SH_W-1:0];
      end
      4'd6: begin
        r = 2'd1;
        d = a >> b[SH_W-1:0];
      end
      default: begin
        r = 2'd2;
        d = {DATA_W{1'b0}};
      end
    endcase
    return {r, d};
  endfunction

  // Round-robin grant: scan downward so the port nearest last_q+1 wins last.
  always_comb begin
    int  idx;
    logic pend;
    idx     = 0;
    pend    = 1'b0;
    gnt_vld = 1'b0;
    gnt_idx = {IDX_W{1'b0}};
    for (int k = N_PORTS; k >= 1; k--) begin
      idx     = (int'(last_q) + k) % N_PORTS;
      pend    = (state_q[idx] == S_PEND);
      gnt_vld = gnt_vld | pend;
      gnt_idx = pend ? IDX_W'(idx) : gnt_idx;
    end
  end

  // Per-port command/operand capture and response generation.
  always_comb begin
    last_d = gnt_vld ? gnt_idx : last_q;
    for (int p = 0; p < N_PORTS; p++) begin
      state_d[p] = state_q[p];
      cmd_d[p]   = cmd_q[p];
      op1_d[p]   = op1_q[p];
      op2_d[p]   = op2_q[p];
      resp_d[p]  = 2'd0;
      data_d[p]  = {DATA_W{1'b0}};
      case (state_q[p])
        S_IDLE: begin
          if (req_cmd_in[4*p +: 4] != 4'd0) begin
            state_d[p] = S_OP2;
            cmd_d[p]   = req_cmd_in[4*p +: 4];
            op1_d[p]   = req_data_in[p*DATA_W +: DATA_W];
          end else begin
            state_d[p] = S_IDLE;
          end
        end
        S_OP2: begin
          op2_d[p]   = req_data_in[p*DATA_W +: DATA_W];
          state_d[p] = S_PEND;
        end
        S_PEND: begin
          if (gnt_vld && (gnt_idx == IDX_W'(p))) begin
            {resp_d[p], data_d[p]} = alu(cmd_q[p], op1_q[p], op2_q[p]);
            state_d[p] = S_IDLE;
          end else begin
            state_d[p] = S_PEND;
          end
        end
        default: begin
          state_d[p] = S_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      last_q <= LAST_RST;
      for (int p = 0; p < N_PORTS; p++) begin
        state_q[p] <= S_IDLE;
        cmd_q[p]   <= 4'd0;
        op1_q[p]   <= {DATA_W{1'b0}};
        op2_q[p]   <= {DATA_W{1'b0}};
        resp_q[p]  <= 2'd0;
        data_q[p]  <= {DATA_W{1'b0}};
      end
    end else begin
      last_q <= last_d;
      for (int p = 0; p < N_PORTS; p++) begin
        state_q[p] <= state_d[p];
        cmd_q[p]   <= cmd_d[p];
        op1_q[p]   <= op1_d[p];
        op2_q[p]   <= op2_d[p];
        resp_q[p]  <= resp_d[p];
        data_q[p]  <= data_d[p];
      end
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_lane
    assign out_resp[2*g +: 2]           = resp_q[g];
    assign out_data[g*DATA_W +: DATA_W] = data_q[g];
  end

endmodule

// File: tb/tb_calc2_param.sv
// Bench for calc2_param: three instances (4x32, 4x32 saturating, 2x16) checked every
// cycle against a behavioural queue-free request model, plus directed literal pins.
module tb_calc2_param;

  logic          c_clk = 1'b0;
  logic          rst;
  logic [0:15]   cmd_a_v;
  logic [0:127]  dat_a_v;
  logic [0:7]    resp_a;
  logic [0:127]  odat_a;
  logic [0:7]    resp_s;
  logic [0:127]  odat_s;
  logic [0:7]    cmd_n_v;
  logic [0:31]   dat_n_v;
  logic [0:3]    resp_n;
  logic [0:31]   odat_n;

  calc2_param #(.N_PORTS(4), .DATA_W(32), .SATURATE(0)) dut (
    .c_clk(c_clk), .reset(rst), .req_cmd_in(cmd_a_v), .req_data_in(dat_a_v),
    .out_resp(resp_a), .out_data(odat_a));
  calc2_param #(.N_PORTS(4), .DATA_W(32), .SATURATE(1)) dut_s (
    .c_clk(c_clk), .reset(rst), .req_cmd_in(cmd_a_v), .req_data_in(dat_a_v),
    .out_resp(resp_s), .out_data(odat_s));
  calc2_param #(.N_PORTS(2), .DATA_W(16), .SATURATE(0)) dut_n (
    .c_clk(c_clk), .reset(rst), .req_cmd_in(cmd_n_v), .req_data_in(dat_n_v),
    .out_resp(resp_n), .out_data(odat_n));

  always #5 c_clk = ~c_clk;

  // Stimulus per stimulus-instance (0: the two 4x32 parts, 1: the 2x16 part).
  logic [3:0]      s_cmd [2][4];
  longint unsigned s_dat [2][4];

  // Model: phase 0 idle, 1 waiting op2, 2 waiting for the ALU.
  int              ph    [2][4];
  int              mcmd  [2][4];
  longint unsigned mop1  [2][4];
  longint unsigned mop2  [2][4];
  int              mlast [2];
  // Expected lanes per output instance (0: dut, 1: dut_s, 2: dut_n).
  int              er    [3][4];
  longint unsigned ed    [3][4];

  int n_pass  = 0;
  int n_total = 0;

  function automatic void ref_alu(input int c, input longint unsigned a, input longint unsigned b,
                                  input int w, input bit sat,
                                  output int r, output longint unsigned d);
    longint unsigned m;
    int sh;
    m  = (64'd1 << w) - 64'd1;
    sh = int'(b % longint'(w));
    case (c)
      1: begin
        if (a + b > m) begin r = sat ? 3 : 2; d = sat ? m : 64'd0; end
        else begin r = 1; d = a + b; end
      end
      2: begin
        if (b > a) begin r = sat ? 3 : 2; d = 64'd0; end
        else begin r = 1; d = a - b; end
      end
      5: begin r = 1; d = (a << sh) & m; end
      6: begin r = 1; d = a >> sh; end
      default: begin r = 2; d = 64'd0; end
    endcase
  endfunction

  function automatic int get_resp(input int oi, input int p);
    case (oi)
      0: return int'(resp_a[2*p +: 2]);
      1: return int'(resp_s[2*p +: 2]);
      default: return int'(resp_n[2*p +: 2]);
    endcase
  endfunction

  function automatic longint unsigned get_data(input int oi, input int p);
    case (oi)
      0: return longint'(odat_a[32*p +: 32]);
      1: return longint'(odat_s[32*p +: 32]);
      default: return longint'(odat_n[16*p +: 16]);
    endcase
  endfunction

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic clear_out(input int oi);
    for (int p = 0; p < 4; p++) begin er[oi][p] = 0; ed[oi][p] = 64'd0; end
  endtask

  task automatic model_step(input int si);
    int np, w, g, idx, r, oi;
    longint unsigned d;
    np = (si == 0) ? 4 : 2;
    w  = (si == 0) ? 32 : 16;
    oi = (si == 0) ? 0 : 2;
    clear_out(oi);
    if (si == 0) clear_out(1);
    if (rst) begin
      for (int p = 0; p < 4; p++) ph[si][p] = 0;
      mlast[si] = np - 1;
    end else begin
      g = -1;
      for (int k = 1; k <= np; k++) begin
        idx = (mlast[si] + k) % np;
        if (g < 0 && ph[si][idx] == 2) g = idx;
      end
      if (g >= 0) begin
        ref_alu(mcmd[si][g], mop1[si][g], mop2[si][g], w, 1'b0, r, d);
        er[oi][g] = r; ed[oi][g] = d;
        if (si == 0) begin
          ref_alu(mcmd[si][g], mop1[si][g], mop2[si][g], w, 1'b1, r, d);
          er[1][g] = r; ed[1][g] = d;
        end
        mlast[si] = g;
        ph[si][g] = 0;
      end
      for (int p = 0; p < np; p++) begin
        if (p != g) begin
          if (ph[si][p] == 1) begin
            mop2[si][p] = s_dat[si][p];
            ph[si][p] = 2;
          end else if (ph[si][p] == 0 && s_cmd[si][p] != 4'd0) begin
            mcmd[si][p] = int'(s_cmd[si][p]);
            mop1[si][p] = s_dat[si][p];
            ph[si][p] = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    string nm;
    int np;
    for (int oi = 0; oi < 3; oi++) begin
      nm = (oi == 0) ? "base" : (oi == 1) ? "sat" : "small";
      np = (oi == 2) ? 2 : 4;
      for (int p = 0; p < np; p++) begin
        chk($sformatf("%s_resp[%0d]", nm, p), longint'(get_resp(oi, p)), longint'(er[oi][p]));
        chk($sformatf("%s_data[%0d]", nm, p), get_data(oi, p), ed[oi][p]);
      end
    end
  endtask

  task automatic drive();
    for (int p = 0; p < 4; p++) begin
      cmd_a_v[4*p +: 4]  = s_cmd[0][p];
      dat_a_v[32*p +: 32] = s_dat[0][p][31:0];
    end
    for (int p = 0; p < 2; p++) begin
      cmd_n_v[4*p +: 4]  = s_cmd[1][p];
      dat_n_v[16*p +: 16] = s_dat[1][p][15:0];
    end
  endtask

  task automatic tick();
    drive();
    @(posedge c_clk);
    model_step(0);
    model_step(1);
    @(negedge c_clk);
    compare_all();
  endtask

  task automatic clear_inputs();
    for (int si = 0; si < 2; si++)
      for (int p = 0; p < 4; p++) begin s_cmd[si][p] = 4'd0; s_dat[si][p] = 64'd0; end
  endtask

  // Command edge then operand edge; the caller's next tick is the uncontended grant edge.
  task automatic req(input int si, input int p, input int c, input longint unsigned a,
                     input longint unsigned b);
    s_cmd[si][p] = 4'(c);
    s_dat[si][p] = a;
    tick();
    s_cmd[si][p] = 4'd0;
    s_dat[si][p] = b;
    tick();
    s_dat[si][p] = 64'd0;
  endtask

  task automatic pin(input int oi, input int p, input int r, input longint unsigned d);
    chk($sformatf("pin_dut%0d_resp[%0d]", oi, p), longint'(get_resp(oi, p)), longint'(r));
    chk($sformatf("pin_dut%0d_data[%0d]", oi, p), get_data(oi, p), d);
    chk($sformatf("pin_model%0d_resp[%0d]", oi, p), longint'(er[oi][p]), longint'(r));
    chk($sformatf("pin_model%0d_data[%0d]", oi, p), ed[oi][p], d);
  endtask

  function automatic logic [3:0] rand_cmd();
    if ($urandom_range(0, 9) < 4) return 4'd0;
    case ($urandom_range(0, 5))
      0: return 4'd1;
      1: return 4'd2;
      2: return 4'd5;
      3: return 4'd6;
      default: return 4'($urandom_range(1, 15));
    endcase
  endfunction

  function automatic longint unsigned rand_dat(input int w);
    longint unsigned m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return m;
      3: return (m >> 1) + 64'd1;
      4: return longint'($urandom_range(0, 40));
      default: return longint'($urandom) & m;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    clear_inputs();
    for (int si = 0; si < 2; si++) begin
      mlast[si] = (si == 0) ? 3 : 1;
      for (int p = 0; p < 4; p++) ph[si][p] = 0;
    end
    for (int oi = 0; oi < 3; oi++) clear_out(oi);
    repeat (4) tick();
    pin(0, 0, 0, 64'd0);
    pin(1, 3, 0, 64'd0);
    pin(2, 1, 0, 64'd0);
    rst = 1'b0;

    req(0, 0, 1, 64'h1, 64'h1FFF_FFFF);
    tick();
    pin(0, 0, 1, 64'h2000_0000);
    pin(0, 1, 0, 64'd0);
    tick();
    pin(0, 0, 0, 64'd0);

    req(0, 0, 1, 64'hFFFF_FFFF, 64'h1);
    tick();
    pin(0, 0, 2, 64'd0);
    pin(1, 0, 3, 64'hFFFF_FFFF);

    req(0, 1, 2, 64'h1, 64'hF);
    tick();
    pin(0, 1, 2, 64'd0);
    pin(1, 1, 3, 64'd0);
    req(0, 1, 2, 64'hF, 64'h1);
    tick();
    pin(0, 1, 1, 64'hE);

    req(0, 1, 1, 64'd2, 64'd3);
    tick();
    pin(0, 1, 1, 64'd5);

    for (int p = 0; p < 3; p++) begin s_cmd[0][p] = 4'd1; s_dat[0][p] = 64'(10 * (p + 1)); end
    tick();
    for (int p = 0; p < 3; p++) begin s_cmd[0][p] = 4'd0; s_dat[0][p] = 64'(p + 1); end
    tick();
    clear_inputs();
    tick();
    pin(0, 2, 1, 64'd33);
    pin(0, 0, 0, 64'd0);
    tick();
    pin(0, 0, 1, 64'd11);
    pin(0, 2, 0, 64'd0);
    tick();
    pin(0, 1, 1, 64'd22);
    pin(0, 0, 0, 64'd0);

    req(0, 3, 3, 64'd5, 64'd6);
    tick();
    pin(0, 3, 2, 64'd0);
    pin(1, 3, 2, 64'd0);
    req(0, 3, 4, 64'd7, 64'd8);
    tick();
    pin(0, 3, 2, 64'd0);
    req(0, 3, 5, 64'h1, 64'd31);
    tick();
    pin(0, 3, 1, 64'h8000_0000);
    req(0, 3, 6, 64'h8000_0000, 64'd33);
    tick();
    pin(0, 3, 1, 64'h4000_0000);

    req(0, 2, 1, 64'd7, 64'd8);
    rst = 1'b1;
    tick();
    pin(0, 2, 0, 64'd0);
    pin(0, 0, 0, 64'd0);
    rst = 1'b0;
    repeat (4) begin
      tick();
      pin(0, 2, 0, 64'd0);
    end

    req(1, 0, 1, 64'hFFFF, 64'h1);
    tick();
    pin(2, 0, 2, 64'd0);
    req(1, 1, 1, 64'h7FFF, 64'h1);
    tick();
    pin(2, 1, 1, 64'h8000);

    repeat (3000) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int p = 0; p < 4; p++) begin
        s_cmd[0][p] = rand_cmd();
        s_dat[0][p] = rand_dat(32);
      end
      for (int p = 0; p < 2; p++) begin
        s_cmd[1][p] = rand_cmd();
        s_dat[1][p] = rand_dat(16);
      end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
